// File: rtl/sd_cmd_seq.sv
// sd_cmd_seq: SD-mode card bring-up and CMD17 issue sequencer.
// Drives sdcmd_ctrl; owns clkdiv, RCA and card-type state.
module sd_cmd_seq #(
  parameter logic [15:0] CLKDIV_SLOW  = 16'd60,
  parameter logic [15:0] CLKDIV_FAST  = 16'd0,
  parameter logic [15:0] ACMD41_RETRY = 16'd1000,
  parameter logic [15:0] PRE_INIT     = 16'd100,
  parameter logic [15:0] PRE_CMD      = 16'd8
) (
  input  logic        rstn,
  input  logic        clk,
  output logic [15:0] clkdiv,
  output logic        start,
  output logic [15:0] precnt,
  output logic [5:0]  cmd,
  output logic [31:0] arg,
  input  logic        busy,
  input  logic        done,
  input  logic        timeout,
  input  logic        syntaxe,
  input  logic [31:0] resparg,
  input  logic        rd_req,
  input  logic [31:0] rd_sector,
  output logic        rd_busy,
  output logic        rd_cmd_ok,
  output logic        rd_cmd_err,
  output logic        init_done,
  output logic        init_err,
  output logic        card_v2,
  output logic        sdhc,
  output logic [15:0] rca,
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {
    S_CMD0   = 4'd0,
    S_CMD8   = 4'd1,
    S_CMD55  = 4'd2,
    S_ACMD41 = 4'd3,
    S_CMD2   = 4'd4,
    S_CMD3   = 4'd5,
    S_CMD7   = 4'd6,
    S_CMD16  = 4'd7,
    S_READY  = 4'd8,
    S_CMD17  = 4'd9,
    S_ERROR  = 4'd15
  } state_t;

  state_t      state;
  logic        waiting;
  logic [15:0] retry;
  logic [31:0] sector;
  logic [5:0]  nxt_cmd;
  logic [31:0] nxt_arg;
  logic [15:0] nxt_pre;
  logic        resp_ok;
  logic        unused_bits;

  // Standard-capacity cards take a byte address.
  function automatic logic [31:0] blk_addr(
    input logic        hc,
    input logic [31:0] s
  );
    return hc ? s : {s[22:0], 9'd0};
  endfunction

  assign resp_ok     = !timeout && !syntaxe;
  assign dbg_state   = state;
  assign unused_bits = ^resparg[15:12];

  always_comb begin
    nxt_cmd = 6'd0;
    nxt_arg = 32'd0;
    nxt_pre = PRE_CMD;
    unique case (state)
      S_CMD0:   nxt_pre = PRE_INIT;
      S_CMD8: begin
        nxt_cmd = 6'd8;
        nxt_arg = 32'h0000_01AA;
      end
      S_CMD55:  nxt_cmd = 6'd55;
      S_ACMD41: begin
        nxt_cmd = 6'd41;
        nxt_arg = card_v2 ? 32'h4010_0000
                          : 32'h0010_0000;
      end
      S_CMD2:   nxt_cmd = 6'd2;
      S_CMD3:   nxt_cmd = 6'd3;
      S_CMD7: begin
        nxt_cmd = 6'd7;
        nxt_arg = {rca, 16'h0000};
      end
      S_CMD16: begin
        nxt_cmd = 6'd16;
        nxt_arg = 32'd512;
      end
      S_CMD17: begin
        nxt_cmd = 6'd17;
        nxt_arg = blk_addr(sdhc, sector);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_CMD0;
      waiting    <= 1'b0;
      retry      <= 16'd0;
      sector     <= 32'd0;
      start      <= 1'b0;
      cmd        <= 6'd0;
      arg        <= 32'd0;
      precnt     <= PRE_INIT;
      clkdiv     <= CLKDIV_SLOW;
      rca        <= 16'd0;
      sdhc       <= 1'b0;
      card_v2    <= 1'b0;
      init_done  <= 1'b0;
      init_err   <= 1'b0;
      rd_busy    <= 1'b0;
      rd_cmd_ok  <= 1'b0;
      rd_cmd_err <= 1'b0;
    end else begin
      start      <= 1'b0;
      rd_cmd_ok  <= 1'b0;
      rd_cmd_err <= 1'b0;
      unique case (state)
        S_ERROR: ;
        S_READY: begin
          if (rd_req) begin
            sector  <= rd_sector;
            rd_busy <= 1'b1;
            state   <= S_CMD17;
            waiting <= 1'b0;
            // Skip the issue phase so start follows rd_req directly.
            if (!busy && !done) begin
              start   <= 1'b1;
              cmd     <= 6'd17;
              arg     <= blk_addr(sdhc, rd_sector);
              precnt  <= PRE_CMD;
              waiting <= 1'b1;
            end
          end
        end
        default: begin
          if (!waiting) begin
            if (!busy && !done) begin
              start   <= 1'b1;
              cmd     <= nxt_cmd;
              arg     <= nxt_arg;
              precnt  <= nxt_pre;
              waiting <= 1'b1;
            end
          end else if (done) begin
            waiting <= 1'b0;
            unique case (state)
              S_CMD0: state <= S_CMD8;
              S_CMD8: begin
                if (timeout) begin
                  card_v2 <= 1'b0;
                  state   <= S_CMD55;
                end else if (!syntaxe &&
                    resparg[11:0] == 12'h1AA) begin
                  card_v2 <= 1'b1;
                  state   <= S_CMD55;
                end else begin
                  state    <= S_ERROR;
                  init_err <= 1'b1;
                end
              end
              S_CMD55: begin
                if (resp_ok) begin
                  state <= S_ACMD41;
                end else begin
                  state    <= S_ERROR;
                  init_err <= 1'b1;
                end
              end
              S_ACMD41: begin
                if (timeout) begin
                  state    <= S_ERROR;
                  init_err <= 1'b1;
                end else if (resparg[31]) begin
                  sdhc  <= resparg[30];
                  state <= S_CMD2;
                end else begin
                  retry <= retry + 16'd1;
                  if (retry + 16'd1 >= ACMD41_RETRY) begin
                    state    <= S_ERROR;
                    init_err <= 1'b1;
                  end else begin
                    state <= S_CMD55;
                  end
                end
              end
              S_CMD2: begin
                if (!timeout) begin
                  state <= S_CMD3;
                end else begin
                  state    <= S_ERROR;
                  init_err <= 1'b1;
                end
              end
              S_CMD3: begin
                if (resp_ok) begin
                  rca    <= resparg[31:16];
                  clkdiv <= CLKDIV_FAST;
                  state  <= S_CMD7;
                end else begin
                  state    <= S_ERROR;
                  init_err <= 1'b1;
                end
              end
              S_CMD7: begin
                if (resp_ok) begin
                  state <= S_CMD16;
                end else begin
                  state    <= S_ERROR;
                  init_err <= 1'b1;
                end
              end
              S_CMD16: begin
                if (resp_ok) begin
                  state     <= S_READY;
                  init_done <= 1'b1;
                end else begin
                  state    <= S_ERROR;
                  init_err <= 1'b1;
                end
              end
              S_CMD17: begin
                rd_busy    <= 1'b0;
                rd_cmd_ok  <= resp_ok;
                rd_cmd_err <= !resp_ok;
                state      <= S_READY;
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_seq.sv
// tb_sd_cmd_seq: table-driven command/response checks
// plus hand-written read, retry and reset sequences.
module tb_sd_cmd_seq;

  typedef struct packed {
    logic [5:0]  cmd;
    logic [31:0] arg;
    logic [15:0] pre;
    logic        to;
    logic        sx;
    logic [31:0] resp;
    logic [3:0]  nst;
    logic [15:0] ckd;
  } row_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] clkdiv;
  logic        start;
  logic [15:0] precnt;
  logic [5:0]  cmd;
  logic [31:0] arg;
  logic        busy = 1'b0;
  logic        done = 1'b0;
  logic        timeout = 1'b0;
  logic        syntaxe = 1'b0;
  logic [31:0] resparg = 32'd0;
  logic        rd_req = 1'b0;
  logic [31:0] rd_sector = 32'd0;
  logic        rd_busy;
  logic        rd_cmd_ok;
  logic        rd_cmd_err;
  logic        init_done;
  logic        init_err;
  logic        card_v2;
  logic        sdhc;
  logic [15:0] rca;
  logic [3:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  row_t tbl[$];

  always #5 clk = ~clk;

  sd_cmd_seq #(.ACMD41_RETRY(16'd4)) dut (
    .rstn(rstn), .clk(clk), .clkdiv(clkdiv),
    .start(start), .precnt(precnt), .cmd(cmd),
    .arg(arg), .busy(busy), .done(done),
    .timeout(timeout), .syntaxe(syntaxe),
    .resparg(resparg), .rd_req(rd_req),
    .rd_sector(rd_sector), .rd_busy(rd_busy),
    .rd_cmd_ok(rd_cmd_ok), .rd_cmd_err(rd_cmd_err),
    .init_done(init_done), .init_err(init_err),
    .card_v2(card_v2), .sdhc(sdhc), .rca(rca),
    .dbg_state(dbg_state)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  function automatic row_t mk(
    input logic [5:0] c, input logic [31:0] a,
    input logic to, input logic sx,
    input logic [31:0] rsp, input logic [3:0] ns,
    input logic [15:0] cd);
    row_t r;
    r.cmd = c; r.arg = a;
    r.pre = (c == 6'd0) ? 16'd100 : 16'd8;
    r.to = to; r.sx = sx; r.resp = rsp;
    r.nst = ns; r.ckd = cd;
    return r;
  endfunction

  task automatic wait_start();
    int n = 0;
    while (start !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("start_seen", start, 1);
  endtask

  task automatic xact(input row_t r);
    wait_start();
    chk("cmd", cmd, r.cmd);
    chk("arg", arg, r.arg);
    chk("precnt", precnt, r.pre);
    busy = 1'b1;
    @(negedge clk);
    chk("start_pulse", start, 0);
    @(negedge clk);
    done = 1'b1; timeout = r.to;
    syntaxe = r.sx; resparg = r.resp;
    @(negedge clk);
    done = 1'b0; timeout = 1'b0;
    syntaxe = 1'b0; resparg = 32'd0;
    busy = 1'b0;
    chk("state", dbg_state, r.nst);
    chk("clkdiv", clkdiv, r.ckd);
  endtask

  task automatic run(input int a, input int b);
    for (int i = a; i <= b; i++) xact(tbl[i]);
  endtask

  task automatic do_reset();
    rstn = 1'b0; busy = 1'b0; done = 1'b0;
    timeout = 1'b0; syntaxe = 1'b0; rd_req = 1'b0;
    #1;
    chk("rst_flags", {start, sdhc, card_v2,
        init_done, init_err, rd_busy,
        rd_cmd_ok, rd_cmd_err}, 0);
    chk("rst_cmd", cmd, 0);
    chk("rst_arg", arg, 0);
    chk("rst_precnt", precnt, 100);
    chk("rst_clkdiv", clkdiv, 60);
    chk("rst_rca", rca, 0);
    chk("rst_state", dbg_state, 0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic do_read(input logic [31:0] sec,
                         input logic to,
                         input logic [31:0] earg);
    rd_sector = sec; rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    chk("rd_start", start, 1);
    chk("rd_cmd", cmd, 17);
    chk("rd_arg", arg, earg);
    chk("rd_busy_on", rd_busy, 1);
    busy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    done = 1'b1; timeout = to;
    chk("rd_busy_hold", rd_busy, 1);
    @(negedge clk);
    done = 1'b0; timeout = 1'b0; busy = 1'b0;
    chk("rd_ok", rd_cmd_ok, !to);
    chk("rd_err", rd_cmd_err, to);
    chk("rd_busy_off", rd_busy, 0);
    chk("rd_state", dbg_state, 8);
    @(negedge clk);
    chk("rd_pulse_end", {rd_cmd_ok, rd_cmd_err}, 0);
  endtask

  initial begin
    int seen;
    // v2 SDHC bring-up: rows 0-13
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 60));
    tbl.push_back(mk(8, 32'h1AA, 0, 0, 32'h1AA, 2, 60));
    tbl.push_back(mk(55, 0, 0, 0, 0, 3, 60));
    tbl.push_back(mk(41, 32'h40100000, 0, 0,
                     32'h00FF8000, 2, 60));
    tbl.push_back(mk(55, 0, 0, 0, 0, 3, 60));
    tbl.push_back(mk(41, 32'h40100000, 0, 0,
                     32'h00FF8000, 2, 60));
    tbl.push_back(mk(55, 0, 0, 0, 0, 3, 60));
    tbl.push_back(mk(41, 32'h40100000, 0, 0,
                     32'h00FF8000, 2, 60));
    tbl.push_back(mk(55, 0, 0, 0, 0, 3, 60));
    tbl.push_back(mk(41, 32'h40100000, 0, 0,
                     32'hC0FF8000, 4, 60));
    tbl.push_back(mk(2, 0, 0, 1, 32'h5, 5, 60));
    tbl.push_back(mk(3, 0, 0, 0, 32'h12340000, 6, 0));
    tbl.push_back(mk(7, 32'h12340000, 0, 0, 0, 7, 0));
    tbl.push_back(mk(16, 512, 0, 0, 0, 8, 0));
    // v1 card, CMD8 timeout: rows 14-21
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 60));
    tbl.push_back(mk(8, 32'h1AA, 1, 0, 0, 2, 60));
    tbl.push_back(mk(55, 0, 0, 0, 0, 3, 60));
    tbl.push_back(mk(41, 32'h00100000, 0, 1,
                     32'h80FF8000, 4, 60));
    tbl.push_back(mk(2, 0, 0, 0, 0, 5, 60));
    tbl.push_back(mk(3, 0, 0, 0, 32'h00010000, 6, 0));
    tbl.push_back(mk(7, 32'h00010000, 0, 0, 0, 7, 0));
    tbl.push_back(mk(16, 512, 0, 0, 0, 8, 0));
    // ACMD41 never ready: rows 22-31
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 60));
    tbl.push_back(mk(8, 32'h1AA, 0, 0, 32'h1AA, 2, 60));
    for (int i = 0; i < 4; i++) begin
      tbl.push_back(mk(55, 0, 0, 0, 0, 3, 60));
      tbl.push_back(mk(41, 32'h40100000, 0, 0, 0,
                       (i == 3) ? 4'd15 : 4'd2, 60));
    end
    // bad CMD8 echo: rows 32-33; CMD3 timeout: row 34
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 60));
    tbl.push_back(mk(8, 32'h1AA, 0, 0, 32'h1A5, 15, 60));
    tbl.push_back(mk(3, 0, 1, 0, 32'h12340000, 15, 60));

    @(negedge clk);
    do_reset();
    run(0, 13);
    chk("v2_card_v2", card_v2, 1);
    chk("v2_sdhc", sdhc, 1);
    chk("v2_rca", rca, 16'h1234);
    chk("v2_init_done", init_done, 1);
    do_read(32'h00ABCDEF, 0, 32'h00ABCDEF);
    do_read(32'h00ABCDEF, 1, 32'h00ABCDEF);

    do_reset();
    run(14, 21);
    chk("v1_card_v2", card_v2, 0);
    chk("v1_sdhc", sdhc, 0);
    do_read(32'd3, 0, 32'h00000600);

    do_reset();
    run(22, 31);
    chk("retry_init_err", init_err, 1);
    chk("retry_init_done", init_done, 0);
    rd_sector = 32'd1; rd_req = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (start) seen++;
    end
    rd_req = 1'b0;
    chk("err_no_start", seen, 0);
    chk("err_state", dbg_state, 15);

    do_reset();
    run(32, 33);
    chk("cmd8_bad_err", init_err, 1);

    do_reset();
    run(0, 10);
    xact(tbl[34]);
    chk("cmd3_to_rca", rca, 0);
    chk("cmd3_to_err", init_err, 1);

    // reset during ACMD41 WAIT after two not-ready replies
    do_reset();
    run(0, 6);
    wait_start();
    chk("mid_cmd", cmd, 41);
    busy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    do_reset();
    run(0, 13);
    chk("post_rst_ready", init_done, 1);
    chk("post_rst_rca", rca, 16'h1234);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
